// File: rtl/iic_byte_ctrl.sv
// rtl/iic_byte_ctrl.sv - I2C byte write / random read sequencer; optional IIC_CLK_STRETCH_EN
module iic_byte_ctrl #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_ACK1, S_WADDR, S_ACK2, S_WDATA, S_ACK3,
        S_RSTART, S_DEVR, S_ACK4, S_RDATA, S_NACK, S_STOP, S_FIN
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [11:0] cnt;
    logic [1:0]  phase;
    logic [2:0]  bit_idx;
    logic        rw_q, nack;
    logic [7:0]  addr_q, wdata_q, rx, tx_byte;
    logic        active, accept, stall, tick, byte_slot, ack_slot, scl_mid;

    assign active = (state != S_IDLE) && (state != S_FIN);
    assign accept = (state == S_IDLE) && start && !done;
    assign busy   = (state != S_IDLE);
    assign sda_o  = 1'b0;
    assign tick   = active && (cnt == CNT_MAX) && !stall;

`ifdef IIC_CLK_STRETCH_EN
    // Slave holding SCL low while we release it freezes the bit timebase.
    assign stall = active && scl_mid && scl && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stall        = 1'b0;
`endif

    always_comb begin
        tx_byte   = '0;
        scl       = 1'b1;
        sda_oe    = 1'b0;
        scl_mid   = (phase == 2'd1) || (phase == 2'd2);
        byte_slot = state inside {S_DEVW, S_WADDR, S_WDATA, S_DEVR, S_RDATA};
        ack_slot  = state inside {S_ACK1, S_ACK2, S_ACK3, S_ACK4};
        case (state)
            S_DEVW:  tx_byte = {DEV_ADDR, 1'b0};
            S_WADDR: tx_byte = addr_q;
            S_WDATA: tx_byte = wdata_q;
            S_DEVR:  tx_byte = {DEV_ADDR, 1'b1};
            default: tx_byte = '0;
        endcase
        case (state)
            S_IDLE, S_FIN: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
            S_START, S_RSTART: begin
                scl    = (phase != 2'd3);
                sda_oe = phase[1];
            end
            S_STOP: begin
                scl    = (phase != 2'd0);
                sda_oe = !phase[1];
            end
            S_DEVW, S_WADDR, S_WDATA, S_DEVR: begin
                scl    = scl_mid;
                sda_oe = !tx_byte[3'd7 - bit_idx];
            end
            default: begin
                scl    = scl_mid;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (accept) state_nxt = S_START;
        end else if (state == S_FIN) begin
            state_nxt = S_IDLE;
        end else if (tick && phase == 2'd3) begin
            case (state)
                S_START:  state_nxt = S_DEVW;
                S_DEVW:   if (bit_idx == 3'd7) state_nxt = S_ACK1;
                S_ACK1:   state_nxt = nack ? S_STOP : S_WADDR;
                S_WADDR:  if (bit_idx == 3'd7) state_nxt = S_ACK2;
                S_ACK2:   state_nxt = nack ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
                S_WDATA:  if (bit_idx == 3'd7) state_nxt = S_ACK3;
                S_ACK3:   state_nxt = S_STOP;
                S_RSTART: state_nxt = S_DEVR;
                S_DEVR:   if (bit_idx == 3'd7) state_nxt = S_ACK4;
                S_ACK4:   state_nxt = nack ? S_STOP : S_RDATA;
                S_RDATA:  if (bit_idx == 3'd7) state_nxt = S_NACK;
                S_NACK:   state_nxt = S_STOP;
                S_STOP:   state_nxt = S_FIN;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            phase   <= '0;
            bit_idx <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rx      <= '0;
            nack    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                cnt     <= '0;
                phase   <= '0;
                bit_idx <= '0;
                if (accept) begin
                    rw_q    <= rw;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    nack    <= 1'b0;
                    ack_err <= 1'b0;
                end
            end else if (state == S_FIN) begin
                done    <= 1'b1;
                ack_err <= nack;
                if (rw_q && !nack) rdata <= rx;
            end else begin
                if (!stall) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 12'd1;
                if (tick) begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd2) begin
                        if (ack_slot && sda_i) nack <= 1'b1;
                        if (state == S_RDATA) rx <= {rx[6:0], sda_i};
                    end
                    if (phase == 2'd3 && byte_slot) bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_byte_ctrl.sv
// tb/tb_iic_byte_ctrl.sv - scoreboard bench for iic_byte_ctrl with EEPROM slave model
module tb_iic_byte_ctrl;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl, sda_o, sda_oe;
    logic       slave_pull = 1'b0;
    logic       stretch_hold = 1'b0;
    wire        sda_line = !(sda_oe || slave_pull);
    wire        scl_line = scl && !stretch_hold;

    iic_byte_ctrl #(.CLK_DIV(DIV), .DEV_ADDR(7'b1010000)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl),
        .sda_o(sda_o), .sda_oe(sda_oe), .sda_i(sda_line), .scl_i(scl_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and 24Cxx slave: decodes bytes on SCL rise, drives SDA on SCL fall.
    logic [7:0] cap[$];
    logic [7:0] sh = 8'h00;
    logic [7:0] sdata_cfg = 8'h00;
    int  bitcnt = 0;
    int  bif = 0;
    int  nack_idx = -1;
    bit  reading = 1'b0;
    bit  stop_seen = 1'b0;
    bit  last_ack = 1'b0;

    always @(negedge sda_line) if (scl === 1'b1) begin
        bitcnt  = 0;
        bif     = 0;
        reading = 1'b0;
    end

    always @(posedge sda_line) if (scl === 1'b1) stop_seen = 1'b1;

    always @(posedge scl) begin
        if (bitcnt < 8) begin
            sh = {sh[6:0], sda_line};
            bitcnt++;
            if (bitcnt == 8) begin
                cap.push_back(sh);
                if (bif == 0) reading = sh[0];
            end
        end else if (bitcnt == 8) begin
            last_ack = sda_line;
            bitcnt   = 9;
        end
    end

    always @(negedge scl) begin
        if (bitcnt == 8)
            slave_pull = (!reading || bif == 0) ? (nack_idx != cap.size() - 1) : 1'b0;
        else if (bitcnt == 9) begin
            bitcnt     = 0;
            bif++;
            slave_pull = reading && bif == 1 && !sdata_cfg[7];
        end else if (bitcnt >= 1 && reading && bif == 1)
            slave_pull = !sdata_cfg[7 - bitcnt];
        else
            slave_pull = 1'b0;
    end

    typedef struct {
        int             lat;
        int             nb;
        logic [3:0][7:0] bytes;
        logic [7:0]     rd;
        logic           err;
        bit             rd_ok;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model_rdata = 8'h00;
    int         t0 = 0;

    task automatic push_exp(input bit r, input logic [7:0] a, input logic [7:0] w,
                            input logic [7:0] sd, input int nk, input int extra);
        exp_t e;
        e.err   = (nk >= 0);
        e.rd_ok = r && (nk < 0);
        e.bytes = '0;
        if (nk == 0) begin
            e.nb = 1; e.bytes[0] = 8'hA0; e.lat = 11 * 4 * DIV + 1;
        end else if (!r) begin
            e.nb = 3; e.bytes[0] = 8'hA0; e.bytes[1] = a; e.bytes[2] = w;
            e.lat = 116 * DIV + 1;
        end else begin
            e.nb = 4; e.bytes[0] = 8'hA0; e.bytes[1] = a; e.bytes[2] = 8'hA1; e.bytes[3] = sd;
            e.lat = 156 * DIV + 1;
        end
        e.lat += extra;
        if (e.rd_ok) model_rdata = sd;
        e.rd = model_rdata;
        sbq.push_back(e);
    endtask

    task automatic setup_bus(input bit r, input logic [7:0] a, input logic [7:0] w,
                             input logic [7:0] sd, input int nk);
        cap.delete();
        stop_seen = 1'b0;
        sdata_cfg = sd;
        nack_idx  = nk;
        rw = r; addr = a; wdata = w;
    endtask

    task automatic issue(input bit r, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] sd, input int nk, input int extra);
        @(negedge clk);
        setup_bus(r, a, w, sd, nk);
        start = 1'b1;
        push_exp(r, a, w, sd, nk, extra);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        if (sbq.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(e.lat));
        chk({tag, "_ack_err"}, 32'(ack_err), 32'(e.err));
        chk({tag, "_rdata"}, 32'(rdata), 32'(e.rd));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_stop"}, 32'(stop_seen), 32'd1);
        chk({tag, "_nbytes"}, 32'(cap.size()), 32'(e.nb));
        for (int i = 0; i < e.nb && i < cap.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(e.bytes[i]));
        if (e.rd_ok) chk({tag, "_master_nack"}, 32'(last_ack), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_sda_o", 32'(sda_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b1;

        issue(1'b0, 8'h12, 8'hA5, 8'h00, -1, 0);
        wait_done("wr");

        issue(1'b1, 8'h34, 8'h00, 8'h5C, -1, 0);
        wait_done("rd");

        issue(1'b0, 8'h55, 8'h66, 8'h00, 0, 0);
        wait_done("nack");
        @(negedge clk);
        chk("ack_err_held", 32'(ack_err), 32'd1);

        issue(1'b0, 8'h7E, 8'h3C, 8'h00, -1, 0);
        repeat (9) @(negedge clk);
        rw = 1'b1; addr = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        wait_done("ign");
        setup_bus(1'b0, 8'h21, 8'hC3, 8'h00, -1);
        start = 1'b1;
        @(negedge clk);
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        push_exp(1'b0, 8'h21, 8'hC3, 8'h00, -1, 0);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk("start_after_done_accepted", 32'(busy), 32'd1);
        wait_done("next");

        issue(1'b0, 8'h44, 8'h99, 8'h00, -1, 0);
        repeat (220) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_scl", 32'(scl), 32'd1);
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        void'(sbq.pop_front());
        model_rdata = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 8'h0F, 8'hF0, 8'h00, -1, 0);
        wait_done("postrst");

`ifdef IIC_CLK_STRETCH_EN
        issue(1'b0, 8'h12, 8'hA5, 8'h00, -1, 20);
        fork
            wait_done("stretch");
            begin
                repeat (148) @(negedge clk);
                stretch_hold = 1'b1;
                repeat (20) @(negedge clk);
                stretch_hold = 1'b0;
            end
        join
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
